// File: rtl/mem_responder_if.sv
// Control-to-memory bus between the Mini-SRC MAR/MDR datapath and mem_responder.
// Handshake: Read/Write are levels sampled in IDLE only; mem_done pulses once per access, and the request must drop before the next accept.
interface mem_responder_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              Read;
  logic              Write;
  logic [ADDR_W-1:0] MAR_addr;
  logic [DATA_W-1:0] MDR_wdata;
  logic [DATA_W-1:0] Mdatain;
  logic              mem_done;
  logic              busy;
  logic              req_err;
  logic [2:0]        dbg_state;

  modport master (
    output Read, Write, MAR_addr, MDR_wdata,
    input  Mdatain, mem_done, busy, req_err, dbg_state
  );

  modport slave (
    input  Read, Write, MAR_addr, MDR_wdata,
    output Mdatain, mem_done, busy, req_err, dbg_state
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder with fixed read/write wait states and a one-cycle done pulse.
// Requests are latched at accept; RELEASE holds off re-service until Read and Write both drop.
module mem_responder #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic Clock,
  input  logic clear,
  mem_responder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_WR_WAIT = 3'd2,
    S_DONE    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [3:0] RD_CNT = 4'(READ_LAT - 1);
  localparam logic [3:0] WR_CNT = 4'(WRITE_LAT - 1);
  localparam int         DEPTH  = 1 << ADDR_W;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_done;
  logic              r_busy;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t     w_next_state;
  logic [3:0] w_next_cnt;
  logic       w_accept_rd;
  logic       w_accept_wr;
  logic       w_fire;
  logic       w_err;
  logic       w_busy_next;
  logic       w_mem_we;
  logic       w_rd_load;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_accept_rd  = 1'b0;
    w_accept_wr  = 1'b0;
    w_fire       = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.Read && bus.Write) begin
          w_err        = 1'b1;
          w_next_state = S_RELEASE;
        end else if (bus.Read) begin
          w_accept_rd  = 1'b1;
          w_next_cnt   = RD_CNT;
          w_next_state = S_RD_WAIT;
        end else if (bus.Write) begin
          w_accept_wr  = 1'b1;
          w_next_cnt   = WR_CNT;
          w_next_state = S_WR_WAIT;
        end
      end
      S_RD_WAIT, S_WR_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_fire       = 1'b1;
          w_next_state = S_DONE;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      S_DONE:    w_next_state = S_RELEASE;
      S_RELEASE: if (!bus.Read && !bus.Write) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
    w_busy_next = (w_next_state == S_RD_WAIT) || (w_next_state == S_WR_WAIT);
    w_mem_we    = w_fire && (r_state == S_WR_WAIT);
    w_rd_load   = w_fire && (r_state == S_RD_WAIT);
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_done  <= w_fire;
      r_busy  <= w_busy_next;
      r_err   <= w_err;
      if (w_accept_rd || w_accept_wr) r_addr <= bus.MAR_addr;
      if (w_accept_wr) r_wdata <= bus.MDR_wdata;
      if (w_rd_load) r_rdata <= r_mem[r_addr];
    end
  end

  // The array has no reset; a reset mid-write forces r_state to IDLE, which gates the write off.
  always_ff @(posedge Clock) begin
    if (w_mem_we) r_mem[r_addr] <= r_wdata;
  end

  assign bus.Mdatain   = r_rdata;
  assign bus.mem_done  = r_done;
  assign bus.busy      = r_busy;
  assign bus.req_err   = r_err;
  assign bus.dbg_state = r_state;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the Mini-SRC datapath's MAR/MDR memory interface. It services the Read and Write strobes the control sequence raises against the MAR address. Reads return a word to the MDR input mux on Mdatain. Writes store the MDR output word. Completion is signalled with a one-cycle mem_done handshake and configurable wait states, so the control unit can stall until memory finishes.

Parameters:
ADDR_W, 9, word address width (512-word memory)
DATA_W, 32, data word width
READ_LAT, 2, clock edges from read accept to data valid (legal range 1..15)
WRITE_LAT, 1, clock edges from write accept to array update (legal range 1..15)

Ports:
Clock  in  1  rising-edge clock
clear  in  1  asynchronous active-low reset
Read  in  1  read request level from control
Write  in  1  write request level from control
MAR_addr  in  ADDR_W  word address from MAR
MDR_wdata  in  DATA_W  write data from MDR output
Mdatain  out  DATA_W  read data to MDR input mux
mem_done  out  1  one-cycle completion pulse
busy  out  1  high while an access is in progress
req_err  out  1  one-cycle pulse: Read and Write both high at accept

Behaviour:
- Reset (clear=0, async): state=IDLE, Mdatain=0, mem_done=0, busy=0, req_err=0, counter=0. The memory array is NOT cleared. A pending write is discarded and the array is left untouched. Reset mid-access aborts with no done pulse.
- FSM states: IDLE, RD_WAIT, WR_WAIT, DONE, RELEASE.
- IDLE, Read=1 and Write=0 at an edge (accept edge E0):
  - latch MAR_addr
  - counter=READ_LAT-1
  - go to RD_WAIT
- IDLE, Write=1 and Read=0 at E0:
  - latch MAR_addr and MDR_wdata
  - counter=WRITE_LAT-1
  - go to WR_WAIT
- IDLE, Read=1 and Write=1:
  - no access
  - req_err=1 for one cycle
  - go to RELEASE
- RD_WAIT / WR_WAIT: counter decrements each edge. At the edge where counter==0:
  - RD: Mdatain <= mem[latched addr]
  - WR: mem[latched addr] <= latched data
  - mem_done <= 1
  - go to DONE
- Latency: mem_done and Mdatain valid are registered at edge E0+READ_LAT (read) or E0+WRITE_LAT (write).
- DONE: mem_done=1 for exactly one cycle, then RELEASE.
- RELEASE: wait until Read=0 and Write=0 at an edge, then go to IDLE. This stops a request held high across several cycles from being serviced twice.
- Requests are latched at accept. Deasserting Read/Write or changing MAR_addr/MDR_wdata during a WAIT state does not affect the access in flight.
- busy=1 in RD_WAIT and WR_WAIT only (registered with state).
- Mdatain holds the last read data until the next read completes. Writes never change Mdatain, including a write to the address last read.
- Address is a full ADDR_W index; no out-of-range case exists.
- Back-to-back minimum spacing: accept, WAIT×LAT, DONE, RELEASE (≥1 cycle with requests low), IDLE.

Test Plan:
- Reset: hold clear=0 with Read=1 -> Mdatain=0, mem_done=0, busy=0. Release, then Write 0x00000009 to addr 0x095 -> mem_done exactly at E0+1, busy high 1 cycle.
- Read after write, READ_LAT=2: Read at addr 0x095 -> busy high for 2 cycles, Mdatain=0x00000009 and mem_done pulse at E0+2; Mdatain holds 0x00000009 afterwards.
- Held request: keep Read=1 for 6 cycles -> exactly one mem_done pulse; a second access is accepted only after Read drops for ≥1 cycle.
- Simultaneous Read=Write=1 -> req_err pulse, no mem_done, array at the addressed word unchanged on a later read.
- Mid-access changes: during RD_WAIT change MAR_addr to 0x034 and drop Read -> returned data is from 0x095. During WR_WAIT change MDR_wdata -> the original data is stored.
- Reset mid-write: assert clear during WR_WAIT for data 0xDEADBEEF to addr 0x010 (previously 0x00800034) -> no mem_done; a later read of 0x010 returns 0x00800034.
